// File: rtl/sata_defines.sv
// Shared definitions for the SATA link supervisor: state encodings, widths,
// parameter defaults and the backoff load helper.
package sata_defines;

    typedef enum logic [2:0] {
        ST_DISABLED  = 3'd0,
        ST_RESET_OOB = 3'd1,
        ST_TRAINING  = 3'd2,
        ST_BACKOFF   = 3'd3,
        ST_LINKED    = 3'd4,
        ST_FAILED    = 3'd5
    } sup_state_e;

    localparam int unsigned TIMER_W     = 32;
    localparam int unsigned RETRY_W     = 4;
    localparam int unsigned OOB_STATE_W = 4;
    localparam int unsigned SUP_STATE_W = 3;
    localparam int unsigned STAT_W      = 16;

    localparam logic [31:0] DEF_TRAIN_TIMEOUT = 32'd2000000;
    localparam logic [15:0] DEF_RESET_HOLD    = 16'd16;
    localparam logic [31:0] DEF_BACKOFF_BASE  = 32'd1024;

    // Timer load for a backoff window: (base << min(retries, shift_max)) - 1, truncated to 32 bits.
    function automatic logic [TIMER_W-1:0] backoff_load(input logic [TIMER_W-1:0] base,
                                                        input logic [RETRY_W-1:0] retries,
                                                        input int unsigned        shift_max);
        int unsigned sh;
        sh = (32'(retries) < shift_max) ? 32'(retries) : shift_max;
        return (base << sh) - TIMER_W'(1);
    endfunction

endpackage

// File: rtl/sata_link_supervisor_if.sv
// Control/status bundle between the platform side and the link supervisor.
// Optional SATA_SUPERVISOR_STATS_EN adds the link_drop_count/attempt_count statistics.
interface sata_link_supervisor_if;
    import sata_defines::*;

    logic                   enable;
    logic                   platform_ready_in;
    logic                   retrain_req;
    logic                   oob_linkup;
    logic [OOB_STATE_W-1:0] oob_state;
    logic                   oob_rst;
    logic                   oob_platform_ready;
    logic                   link_up;
    logic                   link_failed;
    logic [RETRY_W-1:0]     retry_count;
    logic [OOB_STATE_W-1:0] fail_oob_state;
    logic [SUP_STATE_W-1:0] sup_state;
`ifdef SATA_SUPERVISOR_STATS_EN
    logic [STAT_W-1:0]      link_drop_count;
    logic [STAT_W-1:0]      attempt_count;
`endif

    modport master (
        output enable, platform_ready_in, retrain_req, oob_linkup, oob_state,
`ifdef SATA_SUPERVISOR_STATS_EN
        input  link_drop_count, attempt_count,
`endif
        input  oob_rst, oob_platform_ready, link_up, link_failed,
               retry_count, fail_oob_state, sup_state
    );

    modport slave (
        input  enable, platform_ready_in, retrain_req, oob_linkup, oob_state,
`ifdef SATA_SUPERVISOR_STATS_EN
        output link_drop_count, attempt_count,
`endif
        output oob_rst, oob_platform_ready, link_up, link_failed,
               retry_count, fail_oob_state, sup_state
    );

endinterface

// File: rtl/sata_sup_timer.sv
// 32-bit loadable down-counter; expired is registered and tracks count==0.
module sata_sup_timer
    import sata_defines::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] value,
    output logic               expired
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b1;
        end else if (load) begin
            count   <= value;
            expired <= (value == '0);
        end else if (count != '0) begin
            count   <= count - TIMER_W'(1);
            expired <= (count == TIMER_W'(1));
        end
    end

endmodule

// File: rtl/sata_link_supervisor.sv
// Supervises the SATA OOB controller: reset window, training watchdog, backoff retries, link-drop recovery.
// Optional SATA_SUPERVISOR_STATS_EN adds saturating link-drop and training-attempt counters.
module sata_link_supervisor
    import sata_defines::*;
#(
    parameter logic [31:0] TRAIN_TIMEOUT     = DEF_TRAIN_TIMEOUT,
    parameter logic [15:0] RESET_HOLD        = DEF_RESET_HOLD,
    parameter logic [31:0] BACKOFF_BASE      = DEF_BACKOFF_BASE,
    parameter int unsigned BACKOFF_SHIFT_MAX = 3,
    parameter int unsigned MAX_RETRIES       = 8
)(
    input logic                 clk,
    input logic                 rst,
    sata_link_supervisor_if.slave bus
);

    localparam logic [TIMER_W-1:0] RESET_LOAD  = TIMER_W'(RESET_HOLD) - TIMER_W'(1);
    localparam logic [TIMER_W-1:0] TRAIN_LOAD  = TRAIN_TIMEOUT - TIMER_W'(1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRIES);

    sup_state_e             state_q;
    sup_state_e             state_d;
    logic                   tmr_load;
    logic [TIMER_W-1:0]     tmr_value;
    logic                   tmr_expired;
    logic [RETRY_W-1:0]     retry_q;
    logic [RETRY_W-1:0]     retry_d;
    logic [RETRY_W-1:0]     retry_inc;
    logic [OOB_STATE_W-1:0] fail_q;
    logic [OOB_STATE_W-1:0] fail_d;

    sata_sup_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .value   (tmr_value),
        .expired (tmr_expired)
    );

    assign retry_inc = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);

    // Next-state, timer load and counter updates; global overrides precede per-state rules.
    always_comb begin
        state_d   = state_q;
        tmr_load  = 1'b0;
        tmr_value = RESET_LOAD;
        retry_d   = retry_q;
        fail_d    = fail_q;

        if (!bus.enable) begin
            state_d = ST_DISABLED;
            retry_d = '0;
        end else if (!bus.platform_ready_in && state_q != ST_DISABLED) begin
            state_d = ST_DISABLED;
        end else if (bus.retrain_req &&
                     state_q inside {ST_RESET_OOB, ST_TRAINING, ST_BACKOFF, ST_LINKED, ST_FAILED}) begin
            state_d  = ST_RESET_OOB;
            tmr_load = 1'b1;
            if (state_q == ST_FAILED) retry_d = '0;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    if (bus.platform_ready_in) begin
                        state_d  = ST_RESET_OOB;
                        tmr_load = 1'b1;
                    end
                end
                ST_RESET_OOB: begin
                    if (tmr_expired) begin
                        state_d   = ST_TRAINING;
                        tmr_load  = 1'b1;
                        tmr_value = TRAIN_LOAD;
                    end
                end
                ST_TRAINING: begin
                    // linkup beats a simultaneous watchdog expiry
                    if (bus.oob_linkup) begin
                        state_d = ST_LINKED;
                        retry_d = '0;
                    end else if (tmr_expired) begin
                        fail_d  = bus.oob_state;
                        retry_d = retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_d = ST_FAILED;
                        end else begin
                            state_d   = ST_BACKOFF;
                            tmr_load  = 1'b1;
                            tmr_value = backoff_load(BACKOFF_BASE, retry_q, BACKOFF_SHIFT_MAX);
                        end
                    end
                end
                ST_BACKOFF: begin
                    if (tmr_expired) begin
                        state_d  = ST_RESET_OOB;
                        tmr_load = 1'b1;
                    end
                end
                ST_LINKED: begin
                    if (!bus.oob_linkup) begin
                        state_d  = ST_RESET_OOB;
                        tmr_load = 1'b1;
                    end
                end
                ST_FAILED: begin
                    state_d = ST_FAILED;
                end
                default: begin
                    state_d = ST_DISABLED;
                end
            endcase
        end
    end

    // State and registered outputs; outputs follow the next state so they align with sup_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q                <= ST_DISABLED;
            retry_q                <= '0;
            fail_q                 <= '0;
            bus.oob_rst            <= 1'b1;
            bus.oob_platform_ready <= 1'b0;
            bus.link_up            <= 1'b0;
            bus.link_failed        <= 1'b0;
        end else begin
            state_q                <= state_d;
            retry_q                <= retry_d;
            fail_q                 <= fail_d;
            bus.oob_rst            <= !(state_d inside {ST_TRAINING, ST_LINKED});
            bus.oob_platform_ready <= state_d inside {ST_RESET_OOB, ST_TRAINING, ST_LINKED};
            bus.link_up            <= (state_q == ST_LINKED) && (state_d == ST_LINKED);
            bus.link_failed        <= (state_d == ST_FAILED);
        end
    end

    assign bus.retry_count    = retry_q;
    assign bus.fail_oob_state = fail_q;
    assign bus.sup_state      = state_q;

`ifdef SATA_SUPERVISOR_STATS_EN
    logic              link_drop;
    logic              stats_clr;
    logic              train_entry;
    logic [STAT_W-1:0] drop_q;
    logic [STAT_W-1:0] attempt_q;

    // A drop is a LINKED exit caused by linkup falling, not by a retrain request.
    assign link_drop   = (state_q == ST_LINKED) && (state_d == ST_RESET_OOB) &&
                         !bus.oob_linkup && !bus.retrain_req;
    assign stats_clr   = (state_q == ST_FAILED) && (state_d == ST_RESET_OOB);
    assign train_entry = (state_d == ST_TRAINING) && (state_q != ST_TRAINING);

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            drop_q    <= '0;
            attempt_q <= '0;
        end else begin
            if (link_drop && drop_q != '1)      drop_q    <= drop_q + STAT_W'(1);
            if (train_entry && attempt_q != '1) attempt_q <= attempt_q + STAT_W'(1);
        end
    end

    assign bus.link_drop_count = drop_q;
    assign bus.attempt_count   = attempt_q;
`endif

endmodule

// File: tb/tb_sata_link_supervisor.sv
// Self-checking bench for sata_link_supervisor: directed test-plan steps plus randomized
// retry/link/drop sequences predicted from timing arithmetic.
`timescale 1ns/1ps
module tb_sata_link_supervisor;
    import sata_defines::*;

    localparam int TB_TRAIN   = 100;
    localparam int TB_HOLD    = 4;
    localparam int TB_BASE    = 8;
    localparam int TB_SHIFT   = 3;
    localparam int TB_RETRIES = 3;

    localparam int S_DIS = 0, S_RST = 1, S_TRN = 2, S_BOF = 3, S_LNK = 4, S_FAIL = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    sata_link_supervisor_if bus();

    sata_link_supervisor #(
        .TRAIN_TIMEOUT     (32'(TB_TRAIN)),
        .RESET_HOLD        (16'(TB_HOLD)),
        .BACKOFF_BASE      (32'(TB_BASE)),
        .BACKOFF_SHIFT_MAX (TB_SHIFT),
        .MAX_RETRIES       (TB_RETRIES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Backoff window after the (n+1)-th consecutive failure.
    function automatic int exp_backoff(input int n);
        return TB_BASE * (2 ** ((n < TB_SHIFT) ? n : TB_SHIFT));
    endfunction

`ifdef SATA_SUPERVISOR_STATS_EN
    int m_att  = 0;
    int m_drop = 0;
    task automatic stat_attempt(); m_att++;  endtask
    task automatic stat_drop();    m_drop++; endtask
    task automatic stat_clear();   m_att = 0; m_drop = 0; endtask
    task automatic stat_check(input string tag);
        chk({tag, "_attempts"}, 32'(bus.attempt_count), 32'(m_att));
        chk({tag, "_drops"}, 32'(bus.link_drop_count), 32'(m_drop));
    endtask
`else
    task automatic stat_attempt(); endtask
    task automatic stat_drop();    endtask
    task automatic stat_clear();   endtask
    task automatic stat_check(input string tag); endtask
`endif

    // Entered on cycle 1 of state st; returns once the state has changed.
    task automatic stay(input int st, input int exp_len, input string tag);
        int n = 1;
        chk({tag, "_enter"}, 32'(bus.sup_state), 32'(st));
        tick();
        while (int'(bus.sup_state) == st && n < 1000) begin
            n++;
            tick();
        end
        chk({tag, "_len"}, 32'(n), 32'(exp_len));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_state"}, 32'(bus.sup_state), 32'(S_DIS));
        chk({tag, "_oob_rst"}, 32'(bus.oob_rst), 32'd1);
        chk({tag, "_oob_pr"}, 32'(bus.oob_platform_ready), 32'd0);
        chk({tag, "_link_up"}, 32'(bus.link_up), 32'd0);
        chk({tag, "_link_failed"}, 32'(bus.link_failed), 32'd0);
        chk({tag, "_retry"}, 32'(bus.retry_count), 32'd0);
        chk({tag, "_fail_st"}, 32'(bus.fail_oob_state), 32'd0);
    endtask

    // One failing attempt starting at RESET_OOB cycle 1; i = failures already counted.
    task automatic attempt_fail(input int i, input logic [3:0] os, input bit full_backoff);
        bus.oob_state = os;
        stay(S_RST, TB_HOLD, "hold");
        chk("train_oob_rst", 32'(bus.oob_rst), 32'd0);
        chk("train_oob_pr", 32'(bus.oob_platform_ready), 32'd1);
        stat_attempt();
        stay(S_TRN, TB_TRAIN, "train");
        chk("retry_after_fail", 32'(bus.retry_count), 32'(i + 1));
        chk("fail_oob_state", 32'(bus.fail_oob_state), 32'(os));
        if (i + 1 == TB_RETRIES) begin
            chk("failed_state", 32'(bus.sup_state), 32'(S_FAIL));
            chk("failed_flag", 32'(bus.link_failed), 32'd1);
            chk("failed_oob_rst", 32'(bus.oob_rst), 32'd1);
        end else begin
            chk("backoff_oob_rst", 32'(bus.oob_rst), 32'd1);
            chk("backoff_oob_pr", 32'(bus.oob_platform_ready), 32'd0);
            if (full_backoff) stay(S_BOF, exp_backoff(i), "backoff");
        end
    endtask

    // Attempt starting at RESET_OOB cycle 1 that sees linkup on TRAINING cycle k.
    task automatic attempt_link(input int k);
        stay(S_RST, TB_HOLD, "hold");
        stat_attempt();
        repeat (k - 1) tick();
        chk("pre_link_state", 32'(bus.sup_state), 32'(S_TRN));
        bus.oob_linkup = 1'b1;
        tick();
        chk("linked_state", 32'(bus.sup_state), 32'(S_LNK));
        chk("linked_up_first", 32'(bus.link_up), 32'd0);
        chk("linked_retry", 32'(bus.retry_count), 32'd0);
        tick();
        chk("linked_up_second", 32'(bus.link_up), 32'd1);
        chk("linked_hold", 32'(bus.sup_state), 32'(S_LNK));
    endtask

    int fails, k, how;

    initial begin
        bus.enable            = 1'b0;
        bus.platform_ready_in = 1'b0;
        bus.retrain_req       = 1'b0;
        bus.oob_linkup        = 1'b0;
        bus.oob_state         = 4'h0;
        repeat (3) tick();
        check_reset_values("reset");
        stat_check("reset");

        // Exhaust the retry budget with linkup held low
        rst = 1'b0;
        bus.enable            = 1'b1;
        bus.platform_ready_in = 1'b1;
        tick();
        for (int i = 0; i < TB_RETRIES; i++)
            attempt_fail(i, (i == TB_RETRIES - 1) ? 4'h6 : 4'($urandom), 1'b1);
        repeat (5) tick();
        chk("failed_sticky", 32'(bus.sup_state), 32'(S_FAIL));
        chk("failed_retry_kept", 32'(bus.retry_count), 32'(TB_RETRIES));
        stat_check("failed");

        // Retrain out of FAILED
        bus.retrain_req = 1'b1;
        tick();
        bus.retrain_req = 1'b0;
        stat_clear();
        chk("retrain_state", 32'(bus.sup_state), 32'(S_RST));
        chk("retrain_retry", 32'(bus.retry_count), 32'd0);
        chk("retrain_failed", 32'(bus.link_failed), 32'd0);
        stat_check("retrain");

        // Link on training cycle 50, then drop
        attempt_link(50);
        bus.oob_linkup = 1'b0;
        tick();
        stat_drop();
        chk("drop_state", 32'(bus.sup_state), 32'(S_RST));
        chk("drop_link_up", 32'(bus.link_up), 32'd0);
        chk("drop_retry", 32'(bus.retry_count), 32'd0);
        stat_check("drop");

        // Linkup on the exact expiry cycle
        attempt_link(TB_TRAIN);
        bus.oob_linkup = 1'b0;
        tick();
        stat_drop();

        // platform_ready_in lost mid-backoff
        attempt_fail(0, 4'($urandom), 1'b0);
        repeat (3) tick();
        chk("mid_backoff", 32'(bus.sup_state), 32'(S_BOF));
        bus.platform_ready_in = 1'b0;
        tick();
        chk("prlost_state", 32'(bus.sup_state), 32'(S_DIS));
        chk("prlost_oob_pr", 32'(bus.oob_platform_ready), 32'd0);
        chk("prlost_oob_rst", 32'(bus.oob_rst), 32'd1);
        chk("prlost_retry", 32'(bus.retry_count), 32'd1);
        repeat (2) tick();
        chk("prlost_hold", 32'(bus.sup_state), 32'(S_DIS));
        bus.platform_ready_in = 1'b1;
        tick();
        stay(S_RST, TB_HOLD, "restart_hold");
        stat_attempt();
        chk("restart_retry", 32'(bus.retry_count), 32'd1);
        stat_check("restart");

        // Synchronous reset mid-training
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        stat_clear();
        stat_check("midrst");
        rst = 1'b0;
        tick();

        // Randomized: some failures, a link at a random cycle, then a random way out of LINKED
        for (int it = 0; it < 6; it++) begin
            fails = int'($urandom_range(0, TB_RETRIES));
            k     = int'($urandom_range(1, TB_TRAIN));
            how   = int'($urandom_range(0, 2));
            for (int i = 0; i < fails; i++) attempt_fail(i, 4'($urandom), 1'b1);
            if (fails == TB_RETRIES) begin
                bus.retrain_req = 1'b1;
                tick();
                bus.retrain_req = 1'b0;
                stat_clear();
                chk("rnd_retrain_retry", 32'(bus.retry_count), 32'd0);
            end
            attempt_link(k);
            bus.oob_linkup = 1'b0;
            if (how == 0) begin
                tick();
                stat_drop();
            end else if (how == 1) begin
                bus.retrain_req = 1'b1;
                tick();
                bus.retrain_req = 1'b0;
            end else begin
                bus.enable = 1'b0;
                tick();
                chk("rnd_disable_state", 32'(bus.sup_state), 32'(S_DIS));
                chk("rnd_disable_link_up", 32'(bus.link_up), 32'd0);
                bus.enable = 1'b1;
                tick();
            end
            chk("rnd_exit_state", 32'(bus.sup_state), 32'(S_RST));
            chk("rnd_exit_link_up", 32'(bus.link_up), 32'd0);
            chk("rnd_exit_retry", 32'(bus.retry_count), 32'd0);
            stat_check("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
